// File: rtl/dsp_add_pkg.sv
// Shared definitions for the word-serial DSP48E2 add/subtract sequencer:
// FSM state encoding, DSP operand width and the carry-injection packer.
package dsp_add_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DSP_W         = 48;
   // One bit is spent on the injected carry at the bottom and one on the
   // carry-out at the top, leaving this many bits for a limb.
   localparam int MAX_LIMB_BITS = DSP_W - 2;

   // The DSP has no fabric carry-in, so the carry is placed in bit 0 of both
   // operands: {x, c} + {y, c} = 2*(x + y + c), and the sum sits one bit up.
   function automatic logic [DSP_W-1:0] pack_carry(
      input logic [MAX_LIMB_BITS-1:0] limb,
      input logic                     c
   );
      return {1'b0, limb, c};
   endfunction

endpackage

// File: rtl/dsp_wide_add_seq_if.sv
// Limb-stream handshake bundle between a producer of operand limb pairs and
// the wide add/subtract sequencer that returns one result limb per transfer.
interface dsp_wide_add_seq_if #(
   parameter int LIMB_BITS = 32
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic                 in_sub;
   logic [LIMB_BITS-1:0] in_a;
   logic [LIMB_BITS-1:0] in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [LIMB_BITS-1:0] out_sum;
   logic                 out_last;
   logic                 out_carry;

   // Producer side: offers limbs, consumes results.
   modport master (
      output in_valid,
      output in_sub,
      output in_a,
      output in_b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_last,
      input  out_carry
   );

   // Sequencer side.
   modport slave (
      input  in_valid,
      input  in_sub,
      input  in_a,
      input  in_b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_last,
      output out_carry
   );

endinterface

// File: rtl/xilinxdspadd.sv
// Combinational DSP48E2 adder wrapper: result = AB + C (+ PCIN when enabled).
// No internal pipeline registers are used, so the add is purely combinational.
module xilinxdspadd
   import dsp_add_pkg::*;
(
   input  logic [DSP_W-1:0] dataAB,
   input  logic [DSP_W-1:0] dataC,
   input  logic [DSP_W-1:0] pcin,
   input  logic             doAddPcin,
   output logic [DSP_W-1:0] result
);

   logic [DSP_W-1:0] pcin_term;

   // Cascade input contributes only when explicitly enabled.
   always_comb begin
      pcin_term = doAddPcin ? pcin : '0;
      result    = dataAB + dataC + pcin_term;
   end

endmodule

// File: rtl/dsp_wide_add_seq.sv
// Word-serial wide add/subtract sequencer. Operands arrive one limb pair per
// cycle, least-significant limb first; the inter-limb carry is held in a
// register and one result limb is emitted per accepted pair through a single
// output register. One DSP slice is shared by every limb of every operand.
module dsp_wide_add_seq
   import dsp_add_pkg::*;
#(
   parameter int NUM_LIMBS = 32,
   parameter int LIMB_BITS = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   dsp_wide_add_seq_if.slave  bus
);

   localparam int             IDX_W    = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

   generate
      if (LIMB_BITS < 1 || LIMB_BITS > MAX_LIMB_BITS || NUM_LIMBS < 1) begin : g_bad_param
         $error("dsp_wide_add_seq: LIMB_BITS must be 1..%0d and NUM_LIMBS >= 1", MAX_LIMB_BITS);
      end
   endgenerate

   // Sequencing state
   state_t               state_q;
   state_t               state_d;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     idx_d;
   logic                 carry_q;
   logic                 op_sub_q;

   // Limb datapath (stage p0: combinational through the DSP)
   logic                 accept;
   logic                 first_limb;
   logic                 is_last;
   logic                 sub_p0;
   logic                 cin_p0;
   logic [LIMB_BITS-1:0] b_p0;
   logic [DSP_W-1:0]     data_ab_p0;
   logic [DSP_W-1:0]     data_c_p0;
   logic [DSP_W-1:0]     dsp_res_p0;
   logic [LIMB_BITS-1:0] sum_p0;
   logic                 cout_p0;
   logic                 unused_dsp_res;

   // Output register (stage p1)
   logic                 vld_p1;
   logic [LIMB_BITS-1:0] sum_p1;
   logic                 last_p1;
   logic                 carry_p1;

   assign bus.in_ready = rst_n && (!vld_p1 || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // Limb 0 is always taken in IDLE; after that the operation and the carry
   // come from the registers so in_sub is ignored until the next operand.
   assign first_limb   = (state_q == IDLE);
   assign is_last      = (idx_q == LAST_IDX);
   assign sub_p0       = first_limb ? bus.in_sub : op_sub_q;
   assign cin_p0       = first_limb ? bus.in_sub : carry_q;
   assign b_p0         = sub_p0 ? ~bus.in_b : bus.in_b;

   // ---- stage p0: carry injection and the shared DSP add ----
   assign data_ab_p0   = pack_carry(MAX_LIMB_BITS'(bus.in_a), cin_p0);
   assign data_c_p0    = pack_carry(MAX_LIMB_BITS'(b_p0), cin_p0);

   xilinxdspadd u_dsp (
      .dataAB    (data_ab_p0),
      .dataC     (data_c_p0),
      .pcin      ('0),
      .doAddPcin (1'b0),
      .result    (dsp_res_p0)
   );

   assign sum_p0         = dsp_res_p0[LIMB_BITS:1];
   assign cout_p0        = dsp_res_p0[LIMB_BITS+1];
   // Bit 0 and the bits above the carry are always zero by construction.
   assign unused_dsp_res = ^dsp_res_p0;

   // Next-state and limb-counter logic; everything advances only on accept.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (accept) begin
         idx_d = is_last ? '0 : idx_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            // A single-limb operand completes in IDLE and never enters RUN.
            if (accept && !is_last) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept && is_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and limb index; reset discards any partial operand.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Inter-limb carry and the operation latched from limb 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         carry_q  <= 1'b0;
         op_sub_q <= 1'b0;
      end else if (accept) begin
         carry_q  <= cout_p0;
         op_sub_q <= sub_p0;
      end
   end

   // ---- stage p1: output register, reloaded on accept even while popping ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         sum_p1   <= '0;
         last_p1  <= 1'b0;
         carry_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         sum_p1   <= sum_p0;
         last_p1  <= is_last;
         carry_p1 <= cout_p0;
      end else if (bus.out_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_sum   = sum_p1;
   assign bus.out_last  = last_p1;
   assign bus.out_carry = carry_p1;

endmodule

// File: tb/tb_dsp_wide_add_seq.sv
// Scoreboard bench for dsp_wide_add_seq: a 4x32 instance and a 1x46 instance.
// Expected limbs come from whole-operand arithmetic on wide integers.
module tb_dsp_wide_add_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dsp_wide_add_seq_if #(.LIMB_BITS(32)) b4 ();
   dsp_wide_add_seq_if #(.LIMB_BITS(46)) b1 ();

   dsp_wide_add_seq #(.NUM_LIMBS(4), .LIMB_BITS(32)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4.slave)
   );

   dsp_wide_add_seq #(.NUM_LIMBS(1), .LIMB_BITS(46)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1.slave)
   );

   typedef struct packed {
      logic [45:0] sum;
      logic        last;
      logic        carry;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   int   tests    = 0;
   int   fails    = 0;
   int   rdy_mode = 0;

   localparam logic [127:0] ONES128 = {128{1'b1}};
   localparam logic [45:0]  ONES46  = {46{1'b1}};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // out_ready pattern for the 4-limb instance: 0 steady, 1 cycles 1,0,0,1, 2 random
   initial begin : rdy_drv
      int pos;
      pos = 0;
      b4.out_ready = 1'b1;
      b1.out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       b4.out_ready = 1'b1;
            1: begin
               b4.out_ready = (pos % 4 == 0) || (pos % 4 == 3);
               pos++;
            end
            default: b4.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor for the 4-limb instance
   initial begin : mon4
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            check("in_ready4_rule", 64'(b4.in_ready), 64'(!(b4.out_valid && !b4.out_ready)));
            if (b4.out_valid && b4.out_ready) begin
               if (q4.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_out4: got sum 0x%0h with nothing expected", b4.out_sum);
               end else begin
                  e = q4.pop_front();
                  check("sum4", 64'(b4.out_sum), 64'(e.sum));
                  check("last4", 64'(b4.out_last), 64'(e.last));
                  if (e.last) check("carry4", 64'(b4.out_carry), 64'(e.carry));
               end
            end
         end
      end
   end

   // Monitor for the single-limb instance
   initial begin : mon1
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out1: got sum 0x%0h with nothing expected", b1.out_sum);
            end else begin
               e = q1.pop_front();
               check("sum1", 64'(b1.out_sum), 64'(e.sum));
               check("last1", 64'(b1.out_last), 64'(e.last));
               check("carry1", 64'(b1.out_carry), 64'(e.carry));
            end
         end
      end
   end

   // Offer the first nlimbs limbs of a 128-bit operand pair; expectations are
   // pushed as each limb is accepted.
   task automatic send4(input logic [127:0] a, input logic [127:0] b, input bit sub, input int nlimbs);
      logic [128:0] r;
      logic         cy;
      exp_t         e;
      int           tmo;
      if (sub) begin
         r  = {1'b0, a} - {1'b0, b};
         cy = (a >= b);
      end else begin
         r  = {1'b0, a} + {1'b0, b};
         cy = r[128];
      end
      for (int k = 0; k < nlimbs; k++) begin
         @(negedge clk);
         b4.in_valid = 1'b1;
         b4.in_sub   = (k == 0) ? sub : 1'($urandom_range(0, 1));
         b4.in_a     = a[32*k +: 32];
         b4.in_b     = b[32*k +: 32];
         #1;
         tmo = 0;
         while (!b4.in_ready && tmo < 100) begin
            @(negedge clk);
            #1;
            tmo++;
         end
         if (!b4.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout4: in_ready stayed 0, required 1 within 100 cycles");
            break;
         end
         @(posedge clk);
         e.sum   = 46'(r[32*k +: 32]);
         e.last  = (k == 3);
         e.carry = cy;
         q4.push_back(e);
      end
   endtask

   task automatic idle4();
      @(negedge clk);
      b4.in_valid = 1'b0;
      b4.in_a     = $urandom;
      b4.in_b     = $urandom;
   endtask

   task automatic send1(input logic [45:0] a, input logic [45:0] b, input bit sub);
      logic [46:0] r;
      exp_t        e;
      int          tmo;
      if (sub) begin
         r       = {1'b0, a} - {1'b0, b};
         e.carry = (a >= b);
      end else begin
         r       = {1'b0, a} + {1'b0, b};
         e.carry = r[46];
      end
      e.sum  = r[45:0];
      e.last = 1'b1;
      @(negedge clk);
      b1.in_valid = 1'b1;
      b1.in_sub   = sub;
      b1.in_a     = a;
      b1.in_b     = b;
      #1;
      tmo = 0;
      while (!b1.in_ready && tmo < 100) begin
         @(negedge clk);
         #1;
         tmo++;
      end
      if (!b1.in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout1: in_ready stayed 0, required 1 within 100 cycles");
      end else begin
         @(posedge clk);
         q1.push_back(e);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q4.size() != 0 || q1.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      @(negedge clk);
      check("drain_pending", 64'(q4.size() + q1.size()), 64'd0);
   endtask

   function automatic logic [127:0] rnd128();
      if ($urandom_range(0, 4) == 0) return ONES128;
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [45:0] rnd46();
      if ($urandom_range(0, 3) == 0) return ONES46;
      return 46'({$urandom, $urandom});
   endfunction

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      b4.in_valid = 1'b0; b4.in_sub = 1'b0; b4.in_a = '0; b4.in_b = '0;
      b1.in_valid = 1'b0; b1.in_sub = 1'b0; b1.in_a = '0; b1.in_b = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(b4.out_valid), 64'd0);
      check("rst_out_sum", 64'(b4.out_sum), 64'd0);
      check("rst_out_last", 64'(b4.out_last), 64'd0);
      check("rst_out_carry", 64'(b4.out_carry), 64'd0);
      check("rst_in_ready", 64'(b4.in_ready), 64'd0);
      check("rst_out_valid1", 64'(b1.out_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 64'(b4.in_ready), 64'd1);
      check("post_rst_in_ready1", 64'(b1.in_ready), 64'd1);

      // Directed: carry ripple, subtract without and with borrow
      send4(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 4);
      send4(128'd5, 128'd3, 1'b1, 4);
      send4(128'd3, 128'd5, 1'b1, 4);
      idle4();
      drain();

      // Backpressure 1,0,0,1 over back-to-back operands; the first ends with carry 1
      rdy_mode = 1;
      send4(ONES128, 128'd1, 1'b0, 4);
      send4(rnd128(), rnd128(), 1'b0, 4);
      send4(rnd128(), rnd128(), 1'b1, 4);
      idle4();
      drain();

      // Random operands under random backpressure
      rdy_mode = 2;
      for (int n = 0; n < 20; n++) begin
         send4(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 4);
         if ($urandom_range(0, 3) == 0) idle4();
      end
      idle4();
      drain();
      rdy_mode = 0;

      // Reset mid-operand: two limbs accepted with a live carry, then reset
      send4(ONES128, ONES128, 1'b0, 2);
      idle4();
      drain();
      @(negedge clk);
      rst_n = 1'b0;
      b4.in_valid = 1'b1;
      @(negedge clk);
      b4.in_valid = 1'b0;
      check("mid_rst_out_valid", 64'(b4.out_valid), 64'd0);
      check("mid_rst_out_sum", 64'(b4.out_sum), 64'd0);
      check("mid_rst_out_last", 64'(b4.out_last), 64'd0);
      check("mid_rst_out_carry", 64'(b4.out_carry), 64'd0);
      check("mid_rst_in_ready", 64'(b4.in_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      check("mid_post_rst_in_ready", 64'(b4.in_ready), 64'd1);
      send4(rnd128(), {96'd0, 32'hFFFF_FFFF}, 1'b0, 4);
      send4(128'd7, 128'd9, 1'b1, 4);
      idle4();
      drain();

      // Single-limb, maximum-width instance
      send1(ONES46, ONES46, 1'b0);
      send1(46'd0, 46'd1, 1'b1);
      for (int n = 0; n < 10; n++) begin
         send1(rnd46(), rnd46(), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      b1.in_valid = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
